// File: rtl/shift_frame_controller.sv
// Serial shift frame sequencer: accepts a parallel word, shifts it out MSB-first
// one bit per DIV clocks while capturing the serial input into a received word.
module shift_frame_controller #(
  parameter int DIV   = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] start_data,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             abort,
  output logic             ser_out,
  input  logic             ser_in,
  output logic             shift_en,
  output logic             busy,
  output logic [4:0]       bit_count,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] tx_reg;
  // The oldest received bit leaves the shift register on the final tick, so
  // only WIDTH-1 bits need storing; the last bit comes straight from ser_in.
  logic [WIDTH-2:0] rx_reg;
  logic [WIDTH-1:0] rx_data_reg;
  logic [CW-1:0]    div_cnt;
  logic [4:0]       bit_count_reg;
  logic             tick;
  logic             last_bit;

  assign tick     = (state_reg == SHIFT) && (div_cnt == CW'(DIV - 1));
  assign last_bit = tick && (bit_count_reg == 5'(WIDTH - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    start_ready = 1'b0;
    ser_out     = 1'b0;
    shift_en    = 1'b0;
    rx_valid    = 1'b0;
    case (state_reg)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_next = SHIFT;
      end
      SHIFT: begin
        ser_out  = tx_reg[WIDTH-1];
        shift_en = tick;
        // Abort wins over a coincident tick, including the final one.
        if (abort)         state_next = IDLE;
        else if (last_bit) state_next = DONE;
      end
      DONE: begin
        rx_valid   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_reg        <= '0;
      rx_reg        <= '0;
      rx_data_reg   <= '0;
      div_cnt       <= '0;
      bit_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_valid) begin
            tx_reg        <= start_data;
            rx_reg        <= '0;
            div_cnt       <= '0;
            bit_count_reg <= '0;
          end
        end
        SHIFT: begin
          if (abort) begin
            div_cnt       <= '0;
            bit_count_reg <= '0;
          end else if (tick) begin
            div_cnt       <= '0;
            tx_reg        <= {tx_reg[WIDTH-2:0], 1'b0};
            rx_reg        <= {rx_reg[WIDTH-3:0], ser_in};
            bit_count_reg <= bit_count_reg + 5'd1;
            if (last_bit) rx_data_reg <= {rx_reg, ser_in};
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = ~start_ready;
  assign bit_count = bit_count_reg;
  assign rx_data   = rx_data_reg;

endmodule
